// File: rtl/regfile_pkg.sv
// Shared parameters, state type and decode helper for the register-file write-port arbiter.
// The 2-to-4 decode stage is the building block of the word-line decoder.
package regfile_pkg;

   localparam int N_REQ    = 4;
   localparam int IDX_W    = 2;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 64;
   localparam int NUM_REGS = 32;
   localparam int ZERO_REG = 31;
   localparam int MAX_LOCK = 4;
   localparam int CNT_W    = 3;

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   function automatic logic [3:0] dec2to4(input logic en, input logic [1:0] sel);
      return en ? (4'b0001 << sel) : 4'b0000;
   endfunction

endpackage

// File: rtl/regfile_wr_arbiter_wordline_decoder.sv
// One-hot word-line decoder with enable, built as a tree: 1 address bit splits into
// two halves, then two levels of enabled 2-to-4 stages fan out to 32 word lines.
module wordline_decoder
   import regfile_pkg::*;
(
   input  logic                en_i,
   input  logic [ADDR_W-1:0]   addr_i,
   output logic [NUM_REGS-1:0] wordline_o
);

   logic [1:0] top_en;
   logic [7:0] mid_en;

   always_comb begin
      top_en     = {en_i & addr_i[4], en_i & ~addr_i[4]};
      mid_en     = '0;
      wordline_o = '0;
      for (int g = 0; g < 2; g++) begin
         mid_en[g*4 +: 4] = dec2to4(top_en[g], addr_i[3:2]);
      end
      for (int g = 0; g < 8; g++) begin
         wordline_o[g*4 +: 4] = dec2to4(mid_en[g], addr_i[1:0]);
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among four requesters,
// with short locked bursts, a downstream stall and a registered one-hot word line.
module regfile_wr_arbiter
   import regfile_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          lock,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic                      wr_stall,
   output logic [N_REQ-1:0]          gnt,
   output logic                      wr_en,
   output logic [ADDR_W-1:0]         wr_addr,
   output logic [DATA_W-1:0]         wr_data,
   output logic [NUM_REGS-1:0]       wr_wordline
);

   arb_state_t        state_q;
   logic [IDX_W-1:0]  rr_ptr_q;
   logic [IDX_W-1:0]  owner_q;
   logic [CNT_W-1:0]  lock_cnt_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;

   logic              owner_hit;
   logic              burst_more;
   logic              win_found;
   logic [IDX_W-1:0]  win_idx;
   logic [IDX_W-1:0]  scan_idx;
   logic              grant_v;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;

   // Scan runs from the highest offset down so the lowest offset from rr_ptr wins last.
   always_comb begin
      owner_hit  = (state_q == LOCKED) && req[owner_q];
      burst_more = lock[owner_q] && (lock_cnt_q < CNT_W'(MAX_LOCK - 1));
      win_found  = 1'b0;
      win_idx    = '0;
      scan_idx   = '0;
      if (owner_hit) begin
         win_found = 1'b1;
         win_idx   = owner_q;
      end else begin
         for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = rr_ptr_q + IDX_W'(k);
            if (req[scan_idx]) begin
               win_found = 1'b1;
               win_idx   = scan_idx;
            end
         end
      end
      grant_v  = win_found && !wr_stall && !reset;
      gnt      = '0;
      if (grant_v) begin
         gnt[win_idx] = 1'b1;
      end
      win_addr = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
      win_data = req_data[int'(win_idx)*DATA_W +: DATA_W];
   end

   // lock_cnt_q counts grants already given to the owner in this burst; the grant
   // being issued now is number lock_cnt_q+1, so the burst ends once that reaches MAX_LOCK.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         lock_cnt_q <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         wr_en_q <= 1'b0;
         if (grant_v) begin
            wr_addr_q <= win_addr;
            wr_data_q <= win_data;
            wr_en_q   <= (win_addr != ZERO_ADDR);
            rr_ptr_q  <= win_idx + IDX_W'(1);
            if (owner_hit) begin
               if (burst_more) begin
                  lock_cnt_q <= lock_cnt_q + CNT_W'(1);
               end else begin
                  state_q    <= IDLE;
                  lock_cnt_q <= '0;
               end
            end else if (lock[win_idx]) begin
               state_q    <= LOCKED;
               owner_q    <= win_idx;
               lock_cnt_q <= CNT_W'(1);
            end else begin
               state_q    <= IDLE;
               lock_cnt_q <= '0;
            end
         end else if (!wr_stall && (state_q == LOCKED) && !req[owner_q]) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
         end
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

   wordline_decoder u_wordline_decoder (
      .en_i       (wr_en_q),
      .addr_i     (wr_addr_q),
      .wordline_o (wr_wordline)
   );

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus random traffic, checked by a
// scoreboard fed from a queue-level arbitration model.
module tb_regfile_wr_arbiter;
   import regfile_pkg::*;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [N_REQ-1:0]        req;
   logic [N_REQ-1:0]        lock;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic                    wr_stall;
   logic [N_REQ-1:0]        gnt;
   logic                    wr_en;
   logic [ADDR_W-1:0]       wr_addr;
   logic [DATA_W-1:0]       wr_data;
   logic [NUM_REGS-1:0]     wr_wordline;

   regfile_wr_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .lock        (lock),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .wr_stall    (wr_stall),
      .gnt         (gnt),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_wordline (wr_wordline)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   bit   mon_on = 1'b0;

   // Expected write-port state after each edge: {en, addr, data, wordline}.
   logic [3:0]   exp_gnt_q[$];
   logic [101:0] exp_q[$];

   int                m_ptr, m_owner, m_run;
   bit                m_locked;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [101:0] pack_wr(input bit en, input logic [4:0] a, input logic [63:0] d);
      logic [31:0] wl;
      wl = en ? (32'd1 << a) : 32'd0;
      return {en, a, d, wl};
   endfunction

   function automatic logic [255:0] rand_data();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [19:0] pk_addr(input int a0, input int a1, input int a2, input int a3);
      return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
   endfunction

   // Drive one cycle, predict its grant and the write it produces, advance the model.
   task automatic step(input bit rst, input logic [3:0] rq, input logic [3:0] lk,
                       input logic [19:0] ad, input logic [255:0] dt, input bit st,
                       output int won);
      logic [4:0]  a;
      logic [63:0] d;
      reset = rst; req = rq; lock = lk; req_addr = ad; req_data = dt; wr_stall = st;
      won = -1;
      if (rst) begin
         m_ptr = 0; m_owner = 0; m_run = 0; m_locked = 0; m_addr = '0; m_data = '0;
         exp_gnt_q.push_back(4'b0000);
         exp_q.push_back(pack_wr(1'b0, 5'd0, 64'd0));
      end else begin
         if (!st) begin
            if (m_locked && rq[m_owner]) won = m_owner;
            else for (int k = 0; k < 4; k++) if (won < 0 && rq[(m_ptr + k) % 4]) won = (m_ptr + k) % 4;
         end
         if (won >= 0) begin
            a = ad[won*5 +: 5];
            d = dt[won*64 +: 64];
            exp_gnt_q.push_back(4'b0001 << won);
            m_addr = a; m_data = d;
            exp_q.push_back(pack_wr(a != 5'd31, a, d));
            m_ptr = (won + 1) % 4;
            if (m_locked && won == m_owner) begin
               m_run++;
               if (!(lk[won] && m_run < MAX_LOCK)) m_locked = 0;
            end else if (lk[won]) begin
               m_locked = 1; m_owner = won; m_run = 1;
            end else begin
               m_locked = 0;
            end
         end else begin
            exp_gnt_q.push_back(4'b0000);
            exp_q.push_back(pack_wr(1'b0, m_addr, m_data));
            if (!st && m_locked && !rq[m_owner]) m_locked = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if (exp_gnt_q.size() == 0 || exp_q.size() == 0) begin
            chk("queue_underflow", 64'd1, 64'd0);
         end else begin
            logic [3:0]   g;
            logic [101:0] e;
            g = exp_gnt_q.pop_front();
            e = exp_q.pop_front();
            chk("gnt", 64'(gnt), 64'(g));
            chk("wr_en", 64'(wr_en), 64'(e[101]));
            chk("wr_addr", 64'(wr_addr), 64'(e[100:96]));
            chk("wr_data", wr_data, e[95:32]);
            chk("wr_wordline", 64'(wr_wordline), 64'(e[31:0]));
         end
      end
   end

   initial begin
      int           w;
      logic [19:0]  ad;
      logic [255:0] dt;
      bit           pend[4];
      logic [4:0]   paddr[4];
      logic [63:0]  pdata[4];

      reset = 1'b1; req = 4'b1111; lock = 4'b1111; wr_stall = 1'b0;
      req_addr = pk_addr(1, 2, 3, 4); req_data = rand_data();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_gnt", 64'(gnt), 64'd0);
      chk("reset_wr_en", 64'(wr_en), 64'd0);
      chk("reset_wr_addr", 64'(wr_addr), 64'd0);
      chk("reset_wr_data", wr_data, 64'd0);
      chk("reset_wordline", 64'(wr_wordline), 64'd0);

      exp_q.push_back(pack_wr(1'b0, 5'd0, 64'd0));
      mon_on = 1'b1;
      step(1'b1, 4'b0000, 4'b0000, '0, '0, 1'b0, w);
      step(1'b0, 4'b0000, 4'b0000, '0, '0, 1'b0, w);

      ad = pk_addr(1, 2, 5, 7);
      repeat (5) step(1'b0, 4'b1111, 4'b0000, ad, rand_data(), 1'b0, w);

      step(1'b0, 4'b0000, 4'b0000, ad, rand_data(), 1'b0, w);
      ad = pk_addr(9, 17, 0, 0);
      repeat (6) step(1'b0, 4'b0011, 4'b0010, ad, rand_data(), 1'b0, w);

      step(1'b0, 4'b0000, 4'b0000, ad, rand_data(), 1'b0, w);
      ad = pk_addr(0, 0, 12, 0);
      repeat (3) step(1'b0, 4'b0100, 4'b0000, ad, rand_data(), 1'b1, w);
      step(1'b0, 4'b0100, 4'b0000, ad, rand_data(), 1'b0, w);

      ad = pk_addr(3, 4, 6, 31);
      dt = rand_data();
      dt[3*64 +: 64] = 64'hDEAD;
      step(1'b0, 4'b1000, 4'b0000, ad, dt, 1'b0, w);
      step(1'b0, 4'b1111, 4'b0000, ad, rand_data(), 1'b0, w);

      ad = pk_addr(8, 10, 20, 30);
      repeat (2) step(1'b0, 4'b0100, 4'b0100, ad, rand_data(), 1'b0, w);
      step(1'b1, 4'b0100, 4'b0100, ad, rand_data(), 1'b0, w);
      step(1'b0, 4'b0101, 4'b0000, ad, rand_data(), 1'b0, w);

      for (int i = 0; i < 4; i++) begin
         pend[i] = 0; paddr[i] = '0; pdata[i] = '0;
      end
      for (int n = 0; n < 400; n++) begin
         logic [3:0] rq;
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i]  = 1;
               paddr[i] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
               pdata[i] = {$urandom, $urandom};
            end
            rq[i]            = pend[i];
            ad[i*5 +: 5]     = paddr[i];
            dt[i*64 +: 64]   = pdata[i];
         end
         for (int i = 4; i < 8; i++) dt[i*32 +: 32] = '0;
         step(($urandom_range(0, 99) == 0), rq, 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
              ad, dt, ($urandom_range(0, 4) == 0), w);
         if (w >= 0) pend[w] = 0;
      end

      mon_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
